instruction_memory: RTL
=======================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter NB, default 32: instruction word width.
REQ-002 Parameter DEPTH, default 256: number of words; AW = clog2(DEPTH).
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-005 i_pc  input  NB  byte address from the program counter.
REQ-006 i_load_start  input  1  one-cycle pulse; begins a program load at word 0.
REQ-007 i_load_valid  input  1  i_load_byte valid this cycle.
REQ-008 i_load_byte  input  8  program byte from the debug unit, MSB-first per word.
REQ-009 o_load_ready  output  1  loader accepts a byte this cycle.
REQ-010 o_load_done  output  1  program load finished; fetch enabled.
REQ-011 o_word_count  output  AW+1  words written in the current or last load.
REQ-012 o_instruction  output  NB  instruction at i_pc.
REQ-013 o_halt  output  1  o_instruction equals HALT_WORD.

Function
REQ-014 Loader FSM states IDLE, RECV, WRITE and DONE; the SHALL-state after reset is IDLE.
REQ-015 IDLE->RECV on i_load_start: byte count, word address and o_word_count SHALL clear to 0.
REQ-016 RECV: o_load_ready=1; on i_load_valid the byte SHALL shift into the assembly register (first byte -> bits 31:24); the 4th byte SHALL go to WRITE.
REQ-017 WRITE (1 cycle, o_load_ready=0): the word SHALL be written at the word address and the address and o_word_count SHALL increment.
REQ-018 WRITE->DONE if the written word is HALT_WORD or the address reaches DEPTH; otherwise WRITE->RECV.
REQ-019 DONE: o_load_done=1 and o_load_ready=0; the FSM SHALL hold until i_load_start, then go to RECV as in REQ-015.
REQ-020 i_load_start in RECV or WRITE SHALL restart the load (REQ-015); a pending WRITE that cycle SHALL be dropped.
REQ-021 i_load_valid outside RECV SHALL be ignored, with no state change.
REQ-022 Fetch: o_instruction SHALL be a combinational read of word i_pc[AW+1:2]; i_pc[1:0] SHALL be ignored.
REQ-023 o_instruction SHALL be 0 (NOP) when o_load_done=0, or when i_pc[NB-1:AW+2] is nonzero.
REQ-024 o_halt SHALL be combinational, 1 if o_instruction == HALT_WORD (32'hFFFFFFFF).
REQ-025 A word written in WRITE SHALL be readable by fetch from the next cycle.

Reset
REQ-026 i_reset=0 SHALL immediately force IDLE, assembly register, byte count, address, o_word_count, o_load_ready and o_load_done to 0.
REQ-027 Memory array contents SHALL NOT be cleared by reset; fetch still returns NOP until a load completes.
REQ-028 Reset asserted mid-load SHALL abandon the load; i_load_start is needed afterwards.

Configuration
REQ-029 Macro IMEM_READBACK_EN defined: ports i_dbg_addr (AW, in) and o_dbg_word (NB, out) SHALL exist; o_dbg_word is the combinational read of i_dbg_addr, valid in any state.
REQ-030 Macro IMEM_READBACK_EN undefined: these ports and their logic SHALL be absent, with no other behaviour change.

Structure
REQ-031 Shared package SHALL hold HALT_WORD, NOP_WORD, the loader state encoding and the bytes-per-word constant (4).
REQ-032 One sub-module, imem_loader_fsm (FSM, byte assembly, address counter), SHALL drive the write port of the array held in instruction_memory.

Verification
REQ-033 Reset, then load bytes 20 08 00 05 / FF FF FF FF -> o_word_count=2 and o_load_done=1; i_pc=0 -> o_instruction=32'h20080005; i_pc=4 -> o_halt=1.
REQ-034 i_pc=2 after the REQ-033 load -> o_instruction=32'h20080005; i_pc=32'h00010000 -> o_instruction=0.
REQ-035 i_load_start after 2 bytes, then load AA BB CC DD + HALT -> word 0 = 32'hAABBCCDD and o_word_count=2.
REQ-036 DEPTH=4 with 4 non-HALT words -> DONE after the 4th WRITE and o_word_count=4; a 17th byte with i_load_valid=1 is ignored.
REQ-037 i_reset=0 for one cycle mid-word, then i_pc=0 -> o_load_done=0 and o_instruction=0; i_load_valid is ignored until i_load_start.
REQ-038 IMEM_READBACK_EN defined, after the REQ-033 load: i_dbg_addr=1 -> o_dbg_word=32'hFFFFFFFF, including while o_load_done=0 after reset.

Source files
------------

// File: rtl/instruction_memory_pkg.sv
// Shared constants and loader state encoding for the instruction memory and its byte loader.
package instruction_memory_pkg;

  localparam int          BYTES_PER_WORD = 4;
  localparam int          BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/instruction_memory_if.sv
// Load handshake and fetch bus of the instruction memory; master = debug unit / CPU side, slave = memory.
interface instruction_memory_if #(
  parameter int NB    = 32,
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);

  logic [NB-1:0] i_pc;
  logic          i_load_start;
  logic          i_load_valid;
  logic [7:0]    i_load_byte;
  logic          o_load_ready;
  logic          o_load_done;
  logic [AW:0]   o_word_count;
  logic [NB-1:0] o_instruction;
  logic          o_halt;

  modport master (
    output i_pc, i_load_start, i_load_valid, i_load_byte,
    input  o_load_ready, o_load_done, o_word_count, o_instruction, o_halt
  );

  modport slave (
    input  i_pc, i_load_start, i_load_valid, i_load_byte,
    output o_load_ready, o_load_done, o_word_count, o_instruction, o_halt
  );

endinterface

// File: rtl/instruction_memory_loader_fsm.sv
// Byte-serial program loader: assembles MSB-first bytes into words and drives the memory write port.
module imem_loader_fsm
  import instruction_memory_pkg::*;
#(
  parameter  int NB    = 32,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_start,
  input  logic          i_load_valid,
  input  logic [7:0]    i_load_byte,
  output logic          o_load_ready,
  output logic          o_load_done,
  output logic [AW:0]   o_word_count,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [NB-1:0] o_wr_data
);

  localparam logic [AW:0]           LAST_ADDR = (AW+1)'(DEPTH);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  loader_state_t         r_state;
  logic [NB-1:0]         r_word;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [AW:0]           r_addr;
  logic                  r_ready;
  logic                  r_done;
  logic [AW:0]           w_addr_inc;

  assign w_addr_inc = r_addr + 1'b1;

  // A start pulse wins over everything, including a WRITE in progress, which is dropped.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
    end else if (i_load_start) begin
      r_state    <= ST_RECV;
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_RECV: begin
          if (i_load_valid) begin
            r_word <= {r_word[NB-9:0], i_load_byte};
            if (r_byte_cnt == LAST_BYTE) begin
              r_state    <= ST_WRITE;
              r_byte_cnt <= '0;
              r_ready    <= 1'b0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_addr <= w_addr_inc;
          if ((r_word == NB'(HALT_WORD)) || (w_addr_inc == LAST_ADDR)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RECV;
            r_ready <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_load_ready = r_ready;
  assign o_load_done  = r_done;
  assign o_word_count = r_addr;
  assign o_wr_en      = (r_state == ST_WRITE) && !i_load_start;
  assign o_wr_addr    = r_addr[AW-1:0];
  assign o_wr_data    = r_word;

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory with a byte-serial program loader and combinational fetch.
// Optional debug readback port enabled by defining IMEM_READBACK_EN.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter  int NB    = 32,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  instruction_memory_if.slave bus
`ifdef IMEM_READBACK_EN
  ,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [NB-1:0] o_dbg_word
`endif
);

  logic [NB-1:0] r_mem [DEPTH];

  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [NB-1:0] w_wr_data;
  logic [AW-1:0] w_word_idx;
  logic          w_pc_in_range;
  logic          w_unused;

  imem_loader_fsm #(
    .NB    (NB),
    .DEPTH (DEPTH)
  ) u_loader (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load_start (bus.i_load_start),
    .i_load_valid (bus.i_load_valid),
    .i_load_byte  (bus.i_load_byte),
    .o_load_ready (bus.o_load_ready),
    .o_load_done  (bus.o_load_done),
    .o_word_count (bus.o_word_count),
    .o_wr_en      (w_wr_en),
    .o_wr_addr    (w_wr_addr),
    .o_wr_data    (w_wr_data)
  );

  // Array is deliberately outside the reset domain so a program survives a reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  assign w_word_idx    = bus.i_pc[AW+1:2];
  assign w_pc_in_range = (bus.i_pc[NB-1:AW+2] == '0) &&
                         ({1'b0, w_word_idx} < (AW+1)'(DEPTH));
  assign w_unused      = ^bus.i_pc[1:0];

  assign bus.o_instruction = (bus.o_load_done && w_pc_in_range) ? r_mem[w_word_idx]
                                                                : NB'(NOP_WORD);
  assign bus.o_halt        = (bus.o_instruction == NB'(HALT_WORD));

`ifdef IMEM_READBACK_EN
  assign o_dbg_word = r_mem[i_dbg_addr];
`endif

endmodule
